id_ex_stage_reg: RTL and testbench
==================================

ID_EX_STAGE_REG -- requirements
Module: id_ex_stage_reg

Interface
REQ-001 Parameter XLEN, default 32, datapath width.
REQ-002 Parameter REG_ID_W, default 6, register-identifier width (matches forwarding unit ports).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 id_valid  input  1  ID holds a real instruction.
REQ-006 id_rs1, id_rs2, id_rd  input  REG_ID_W each  decoded register IDs.
REQ-007 id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_alu_src  input  1 each  decoded controls.
REQ-008 id_alu_op  input  4  ALU operation code.
REQ-009 id_rs1_data, id_rs2_data, id_imm, id_pc  input  XLEN each  operands, immediate, PC.
REQ-010 flush  input  1  EX-resolved redirect; kills instruction in ID.
REQ-011 ex_stall  input  1  downstream hold request.
REQ-012 ex_valid  output  1  EX-stage instruction valid.
REQ-013 ex_rs1, ex_rs2, ex_rd  output  REG_ID_W each  registered IDs; ex_rs1/ex_rs2/ex_rd drive forwarding unit rs1_id/rs2_id/rd_id_ex.
REQ-014 ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src, ex_alu_op, ex_rs1_data, ex_rs2_data, ex_imm, ex_pc  output  widths as ID counterparts  registered copies.
REQ-015 id_stall  output  1  freeze PC and IF/ID register.
REQ-016 load_use_stall  output  1  load-use hazard detected this cycle.
REQ-017 bubble_count, flush_count  output  16 each  saturating event counters.

Function
REQ-018 load_use_stall SHALL = ex_valid & ex_mem_read & (ex_rd != 0) & id_valid & (ex_rd == id_rs1 | ex_rd == id_rs2) & ~flush & ~ex_stall, combinational.
REQ-019 id_stall SHALL = load_use_stall | ex_stall, combinational; SHALL be 0 whenever flush = 1 and ex_stall = 0.
REQ-020 Per-edge priority SHALL be: flush > ex_stall > load_use_stall > normal load.
REQ-021 flush = 1: ex_valid <= 0 and all ex_* control bits (reg_write, mem_read, mem_write, mem_to_reg, alu_src, alu_op) <= 0; data fields don't-care; flush wins even when ex_stall = 1.
REQ-022 ex_stall = 1 (no flush): every ex_* output SHALL hold its value.
REQ-023 load_use_stall = 1: bubble inserted -- ex_valid <= 0, ex_* controls <= 0, ex_rd <= 0; ID fields not captured (ID re-presents next cycle under id_stall).
REQ-024 Normal: all ex_* <= id_* and ex_valid <= id_valid; when id_valid = 0, controls SHALL load as 0.
REQ-025 Latency SHALL be exactly one cycle from ID input to ex_* output.
REQ-026 A load-use stall SHALL last exactly one cycle per hazard (the bubble clears ex_mem_read).
REQ-027 bubble_count SHALL increment on each edge where a load-use bubble is inserted; flush_count on each edge with flush = 1; both saturate at 0xFFFF, no wrap.
REQ-028 rd = 0 SHALL never trigger load_use_stall.

Reset
REQ-029 reset_n = 0 SHALL immediately, independent of clk, clear every registered output and both counters to 0.
REQ-030 Reset asserted mid-stall or mid-flush SHALL abandon that operation; the first edge after deassertion follows REQ-020 normally.

Structure
REQ-031 XLEN, REG_ID_W, the alu_op encoding type and a packed ex-control struct SHALL live in the shared riscv_pkg package.
REQ-032 Hazard comparison (REQ-018) SHALL be a combinational sub-module load_use_detector; registers and counters stay in id_ex_stage_reg.

Verification
REQ-033 Load x5 in EX (ex_mem_read=1, ex_rd=5), ID id_rs2=5 id_valid=1 -> load_use_stall=1, id_stall=1; next cycle ex_valid=0, ex_reg_write=0, bubble_count=1; following cycle ID instruction captured.
REQ-034 Same as REQ-033 with ex_rd=0 -> load_use_stall=0, no bubble, count unchanged.
REQ-035 flush=1 and ex_stall=1 together, id_valid=1 -> next cycle ex_valid=0, controls 0, flush_count increments, id_stall=1 only from ex_stall.
REQ-036 ex_stall=1 for 3 cycles with ex_pc=0x100 -> ex_pc stays 0x100, ex_valid unchanged, load_use_stall=0.
REQ-037 Force bubble_count to 0xFFFE, two load-use hazards -> reads 0xFFFF after both, not 0x0000.
REQ-038 Drop reset_n between clock edges with ex_valid=1 -> all outputs 0 before next edge; first edge after release loads id_* fields.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared pipeline definitions: datapath widths, ALU opcode encoding, and the
// control bundle carried from ID into EX.
package riscv_pkg;

    localparam int XLEN     = 32;
    localparam int REG_ID_W = 6;
    localparam int CNT_W    = 16;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9,
        ALU_LUI  = 4'd10,
        ALU_PASS = 4'd11
    } alu_op_e;

    typedef struct packed {
        logic    reg_write;
        logic    mem_read;
        logic    mem_write;
        logic    mem_to_reg;
        logic    alu_src;
        alu_op_e alu_op;
    } ex_ctrl_t;

    localparam ex_ctrl_t EX_CTRL_NOP = ex_ctrl_t'('0);

    // Event counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/id_ex_stage_reg_if.sv
// ID/EX boundary bundle: decoded ID fields and hazard controls in, registered
// EX fields, stall indications and event counters out.
interface id_ex_stage_reg_if #(
    parameter int XLEN     = riscv_pkg::XLEN,
    parameter int REG_ID_W = riscv_pkg::REG_ID_W
);
    logic                id_valid;
    logic [REG_ID_W-1:0] id_rs1;
    logic [REG_ID_W-1:0] id_rs2;
    logic [REG_ID_W-1:0] id_rd;
    logic                id_reg_write;
    logic                id_mem_read;
    logic                id_mem_write;
    logic                id_mem_to_reg;
    logic                id_alu_src;
    logic [3:0]          id_alu_op;
    logic [XLEN-1:0]     id_rs1_data;
    logic [XLEN-1:0]     id_rs2_data;
    logic [XLEN-1:0]     id_imm;
    logic [XLEN-1:0]     id_pc;
    logic                flush;
    logic                ex_stall;

    logic                ex_valid;
    logic [REG_ID_W-1:0] ex_rs1;
    logic [REG_ID_W-1:0] ex_rs2;
    logic [REG_ID_W-1:0] ex_rd;
    logic                ex_reg_write;
    logic                ex_mem_read;
    logic                ex_mem_write;
    logic                ex_mem_to_reg;
    logic                ex_alu_src;
    logic [3:0]          ex_alu_op;
    logic [XLEN-1:0]     ex_rs1_data;
    logic [XLEN-1:0]     ex_rs2_data;
    logic [XLEN-1:0]     ex_imm;
    logic [XLEN-1:0]     ex_pc;
    logic                id_stall;
    logic                load_use_stall;
    logic [15:0]         bubble_count;
    logic [15:0]         flush_count;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rd, id_reg_write, id_mem_read,
               id_mem_write, id_mem_to_reg, id_alu_src, id_alu_op,
               id_rs1_data, id_rs2_data, id_imm, id_pc, flush, ex_stall,
        input  ex_valid, ex_rs1, ex_rs2, ex_rd, ex_reg_write, ex_mem_read,
               ex_mem_write, ex_mem_to_reg, ex_alu_src, ex_alu_op,
               ex_rs1_data, ex_rs2_data, ex_imm, ex_pc, id_stall,
               load_use_stall, bubble_count, flush_count
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rd, id_reg_write, id_mem_read,
               id_mem_write, id_mem_to_reg, id_alu_src, id_alu_op,
               id_rs1_data, id_rs2_data, id_imm, id_pc, flush, ex_stall,
        output ex_valid, ex_rs1, ex_rs2, ex_rd, ex_reg_write, ex_mem_read,
               ex_mem_write, ex_mem_to_reg, ex_alu_src, ex_alu_op,
               ex_rs1_data, ex_rs2_data, ex_imm, ex_pc, id_stall,
               load_use_stall, bubble_count, flush_count
    );

endinterface

// File: rtl/id_ex_stage_reg_load_use_detector.sv
// Combinational load-use hazard check between the load sitting in EX and the
// instruction waiting in ID.
module load_use_detector #(
    parameter int REG_ID_W = riscv_pkg::REG_ID_W
) (
    input  logic                ex_valid,
    input  logic                ex_mem_read,
    input  logic [REG_ID_W-1:0] ex_rd,
    input  logic                id_valid,
    input  logic [REG_ID_W-1:0] id_rs1,
    input  logic [REG_ID_W-1:0] id_rs2,
    input  logic                flush,
    input  logic                ex_stall,
    output logic                load_use_stall
);

    logic rd_nonzero;
    logic rd_match;

    // x0 is never a real destination, so a load to it cannot create a hazard.
    assign rd_nonzero = |ex_rd;
    assign rd_match   = (ex_rd == id_rs1) || (ex_rd == id_rs2);

    assign load_use_stall = ex_valid && ex_mem_read && rd_nonzero && id_valid &&
                            rd_match && !flush && !ex_stall;

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with flush, downstream hold, load-use bubble
// insertion and saturating bubble/flush event counters.
module id_ex_stage_reg #(
    parameter int XLEN     = riscv_pkg::XLEN,
    parameter int REG_ID_W = riscv_pkg::REG_ID_W
) (
    input logic               clk,
    input logic               reset_n,
    id_ex_stage_reg_if.slave  bus
);
    import riscv_pkg::*;

    ex_ctrl_t            id_ctrl;
    ex_ctrl_t            ex_ctrl_q;
    logic                ex_valid_q;
    logic [REG_ID_W-1:0] ex_rs1_q;
    logic [REG_ID_W-1:0] ex_rs2_q;
    logic [REG_ID_W-1:0] ex_rd_q;
    logic [XLEN-1:0]     ex_rs1_data_q;
    logic [XLEN-1:0]     ex_rs2_data_q;
    logic [XLEN-1:0]     ex_imm_q;
    logic [XLEN-1:0]     ex_pc_q;
    logic [CNT_W-1:0]    bubble_cnt;
    logic [CNT_W-1:0]    flush_cnt;
    logic                load_use;

    load_use_detector #(.REG_ID_W(REG_ID_W)) u_load_use_detector (
        .ex_valid       (ex_valid_q),
        .ex_mem_read    (ex_ctrl_q.mem_read),
        .ex_rd          (ex_rd_q),
        .id_valid       (bus.id_valid),
        .id_rs1         (bus.id_rs1),
        .id_rs2         (bus.id_rs2),
        .flush          (bus.flush),
        .ex_stall       (bus.ex_stall),
        .load_use_stall (load_use)
    );

    // An invalid ID slot enters EX with all controls quiet.
    always_comb begin
        id_ctrl = EX_CTRL_NOP;
        if (bus.id_valid) begin
            id_ctrl.reg_write  = bus.id_reg_write;
            id_ctrl.mem_read   = bus.id_mem_read;
            id_ctrl.mem_write  = bus.id_mem_write;
            id_ctrl.mem_to_reg = bus.id_mem_to_reg;
            id_ctrl.alu_src    = bus.id_alu_src;
            id_ctrl.alu_op     = alu_op_e'(bus.id_alu_op);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ex_valid_q    <= 1'b0;
            ex_ctrl_q     <= EX_CTRL_NOP;
            ex_rs1_q      <= '0;
            ex_rs2_q      <= '0;
            ex_rd_q       <= '0;
            ex_rs1_data_q <= '0;
            ex_rs2_data_q <= '0;
            ex_imm_q      <= '0;
            ex_pc_q       <= '0;
            bubble_cnt    <= '0;
            flush_cnt     <= '0;
        end else if (bus.flush) begin
            // Data fields are left as-is; with valid and controls cleared they are inert.
            ex_valid_q <= 1'b0;
            ex_ctrl_q  <= EX_CTRL_NOP;
            flush_cnt  <= sat_inc(flush_cnt);
        end else if (bus.ex_stall) begin
            ex_valid_q <= ex_valid_q;
        end else if (load_use) begin
            ex_valid_q <= 1'b0;
            ex_ctrl_q  <= EX_CTRL_NOP;
            ex_rd_q    <= '0;
            bubble_cnt <= sat_inc(bubble_cnt);
        end else begin
            ex_valid_q    <= bus.id_valid;
            ex_ctrl_q     <= id_ctrl;
            ex_rs1_q      <= bus.id_rs1;
            ex_rs2_q      <= bus.id_rs2;
            ex_rd_q       <= bus.id_rd;
            ex_rs1_data_q <= bus.id_rs1_data;
            ex_rs2_data_q <= bus.id_rs2_data;
            ex_imm_q      <= bus.id_imm;
            ex_pc_q       <= bus.id_pc;
        end
    end

    assign bus.ex_valid       = ex_valid_q;
    assign bus.ex_rs1         = ex_rs1_q;
    assign bus.ex_rs2         = ex_rs2_q;
    assign bus.ex_rd          = ex_rd_q;
    assign bus.ex_reg_write   = ex_ctrl_q.reg_write;
    assign bus.ex_mem_read    = ex_ctrl_q.mem_read;
    assign bus.ex_mem_write   = ex_ctrl_q.mem_write;
    assign bus.ex_mem_to_reg  = ex_ctrl_q.mem_to_reg;
    assign bus.ex_alu_src     = ex_ctrl_q.alu_src;
    assign bus.ex_alu_op      = ex_ctrl_q.alu_op;
    assign bus.ex_rs1_data    = ex_rs1_data_q;
    assign bus.ex_rs2_data    = ex_rs2_data_q;
    assign bus.ex_imm         = ex_imm_q;
    assign bus.ex_pc          = ex_pc_q;
    assign bus.load_use_stall = load_use;
    assign bus.id_stall       = load_use || bus.ex_stall;
    assign bus.bubble_count   = bubble_cnt;
    assign bus.flush_count    = flush_cnt;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Scoreboard bench for id_ex_stage_reg: directed ID vectors carry their
// hand-computed EX results, and a monitor checks them one edge later.
module tb_id_ex_stage_reg;

    typedef struct {
        logic        valid;
        logic [5:0]  rs1, rs2, rd;
        logic [4:0]  ctl;        // {reg_write, mem_read, mem_write, mem_to_reg, alu_src}
        logic [3:0]  op;
        logic [31:0] pc;
        logic        flush, stall;
        logic        e_lus, e_ids;
        logic        x_valid;
        logic [4:0]  x_ctl;
        logic [3:0]  x_op;
        logic [5:0]  x_rd, x_rs1, x_rs2;
        logic [31:0] x_pc;
        logic [15:0] x_bub, x_fl;
    } vec_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    vec_t exp_q[$];

    always #5 clk = ~clk;

    id_ex_stage_reg_if bus ();

    id_ex_stage_reg dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    function automatic vec_t mk(
        input logic v, input logic [5:0] r1, input logic [5:0] r2, input logic [5:0] rd,
        input logic [4:0] c, input logic [3:0] o, input logic [31:0] p,
        input logic fl, input logic st, input logic elus, input logic eids,
        input logic xv, input logic [4:0] xc, input logic [3:0] xo,
        input logic [5:0] xrd, input logic [5:0] xr1, input logic [5:0] xr2,
        input logic [31:0] xp, input logic [15:0] xb, input logic [15:0] xf);
        vec_t t;
        t.valid = v;  t.rs1 = r1;  t.rs2 = r2;  t.rd = rd;  t.ctl = c;  t.op = o;
        t.pc = p;  t.flush = fl;  t.stall = st;  t.e_lus = elus;  t.e_ids = eids;
        t.x_valid = xv;  t.x_ctl = xc;  t.x_op = xo;  t.x_rd = xrd;
        t.x_rs1 = xr1;  t.x_rs2 = xr2;  t.x_pc = xp;  t.x_bub = xb;  t.x_fl = xf;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, req, $time);
        end
    endtask

    // Operand data is derived from the PC so data-path checks follow ex_pc.
    task automatic drive(input vec_t v);
        bus.id_valid      = v.valid;
        bus.id_rs1        = v.rs1;
        bus.id_rs2        = v.rs2;
        bus.id_rd         = v.rd;
        {bus.id_reg_write, bus.id_mem_read, bus.id_mem_write,
         bus.id_mem_to_reg, bus.id_alu_src} = v.ctl;
        bus.id_alu_op     = v.op;
        bus.id_pc         = v.pc;
        bus.id_rs1_data   = ~v.pc;
        bus.id_rs2_data   = {v.pc[30:0], 1'b0};
        bus.id_imm        = v.pc + 32'd1;
        bus.flush         = v.flush;
        bus.ex_stall      = v.stall;
    endtask

    task automatic run_vec(input vec_t v);
        @(negedge clk);
        drive(v);
        #1;
        chk("load_use_stall", {31'd0, bus.load_use_stall}, {31'd0, v.e_lus});
        chk("id_stall", {31'd0, bus.id_stall}, {31'd0, v.e_ids});
        exp_q.push_back(v);
    endtask

    task automatic chk_all_zero();
        chk("rst_ex_valid", {31'd0, bus.ex_valid}, 32'd0);
        chk("rst_ctrl", {23'd0, bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write,
                         bus.ex_mem_to_reg, bus.ex_alu_src, bus.ex_alu_op}, 32'd0);
        chk("rst_ids", {14'd0, bus.ex_rs1, bus.ex_rs2, bus.ex_rd}, 32'd0);
        chk("rst_pc", bus.ex_pc, 32'd0);
        chk("rst_rs1_data", bus.ex_rs1_data, 32'd0);
        chk("rst_rs2_data", bus.ex_rs2_data, 32'd0);
        chk("rst_imm", bus.ex_imm, 32'd0);
        chk("rst_counts", {bus.bubble_count, bus.flush_count}, 32'd0);
    endtask

    // Monitor: the stage presents a new EX state after every rising edge.
    initial begin
        vec_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("ex_valid", {31'd0, bus.ex_valid}, {31'd0, e.x_valid});
                chk("ex_ctrl", {23'd0, bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write,
                                bus.ex_mem_to_reg, bus.ex_alu_src, bus.ex_alu_op},
                               {23'd0, e.x_ctl, e.x_op});
                chk("ex_rd", {26'd0, bus.ex_rd}, {26'd0, e.x_rd});
                chk("ex_rs", {20'd0, bus.ex_rs1, bus.ex_rs2}, {20'd0, e.x_rs1, e.x_rs2});
                chk("ex_pc", bus.ex_pc, e.x_pc);
                chk("ex_rs1_data", bus.ex_rs1_data, ~e.x_pc);
                chk("ex_rs2_data", bus.ex_rs2_data, {e.x_pc[30:0], 1'b0});
                chk("ex_imm", bus.ex_imm, e.x_pc + 32'd1);
                chk("bubble_count", {16'd0, bus.bubble_count}, {16'd0, e.x_bub});
                chk("flush_count", {16'd0, bus.flush_count}, {16'd0, e.x_fl});
            end
        end
    end

    initial begin
        vec_t ta[$];
        vec_t tb_[$];
        vec_t rv;

        //            v  rs1 rs2 rd  ctl       op  pc        fl st lus ids | xv xctl      xop xrd xr1 xr2 xpc       bub       fl
        ta.push_back(mk(1, 1,  2,  3, 5'b10000, 0, 32'h010, 0, 0, 0, 0,    1, 5'b10000, 0,  3,  1,  2, 32'h010, 16'd0, 16'd0));
        ta.push_back(mk(1, 1,  0,  5, 5'b11011, 0, 32'h014, 0, 0, 0, 0,    1, 5'b11011, 0,  5,  1,  0, 32'h014, 16'd0, 16'd0));
        ta.push_back(mk(1, 7,  5,  8, 5'b10000, 1, 32'h018, 0, 0, 1, 1,    0, 5'b00000, 0,  0,  1,  0, 32'h014, 16'd1, 16'd0));
        ta.push_back(mk(1, 7,  5,  8, 5'b10000, 1, 32'h018, 0, 0, 0, 0,    1, 5'b10000, 1,  8,  7,  5, 32'h018, 16'd1, 16'd0));
        ta.push_back(mk(1, 2,  3,  0, 5'b11011, 0, 32'h01C, 0, 0, 0, 0,    1, 5'b11011, 0,  0,  2,  3, 32'h01C, 16'd1, 16'd0));
        ta.push_back(mk(1, 0,  0,  9, 5'b10000, 2, 32'h020, 0, 0, 0, 0,    1, 5'b10000, 2,  9,  0,  0, 32'h020, 16'd1, 16'd0));
        ta.push_back(mk(1, 1,  2,  6, 5'b11011, 0, 32'h024, 0, 0, 0, 0,    1, 5'b11011, 0,  6,  1,  2, 32'h024, 16'd1, 16'd0));
        ta.push_back(mk(1, 6,  0, 10, 5'b10000, 3, 32'h028, 1, 1, 0, 1,    0, 5'b00000, 0,  6,  1,  2, 32'h024, 16'd1, 16'd1));
        ta.push_back(mk(1, 3,  4, 11, 5'b11011, 4, 32'h100, 0, 0, 0, 0,    1, 5'b11011, 4, 11,  3,  4, 32'h100, 16'd1, 16'd1));
        for (int i = 0; i < 3; i++)
            ta.push_back(mk(1, 11, 1, 12, 5'b10000, 5, 32'h104, 0, 1, 0, 1, 1, 5'b11011, 4, 11,  3,  4, 32'h100, 16'd1, 16'd1));
        ta.push_back(mk(1, 11, 1, 12, 5'b10000, 5, 32'h104, 0, 0, 1, 1,    0, 5'b00000, 0,  0,  3,  4, 32'h100, 16'd2, 16'd1));
        ta.push_back(mk(1, 11, 1, 12, 5'b10000, 5, 32'h104, 0, 0, 0, 0,    1, 5'b10000, 5, 12, 11,  1, 32'h104, 16'd2, 16'd1));
        ta.push_back(mk(0, 1,  2, 13, 5'b11111, 9, 32'h108, 0, 0, 0, 0,    0, 5'b00000, 0, 13,  1,  2, 32'h108, 16'd2, 16'd1));
        ta.push_back(mk(1, 4,  5, 14, 5'b10000, 1, 32'h10C, 1, 0, 0, 0,    0, 5'b00000, 0, 13,  1,  2, 32'h108, 16'd2, 16'd2));
        // Idle slot; its edge also verifies the preloaded bubble count is held.
        ta.push_back(mk(0, 0,  0,  0, 5'b00000, 0, 32'h000, 0, 0, 0, 0,    0, 5'b00000, 0,  0,  0,  0, 32'h000, 16'hFFFE, 16'd2));

        tb_.push_back(mk(1, 1, 0,  5, 5'b11011, 0, 32'h300, 0, 0, 0, 0,    1, 5'b11011, 0,  5,  1,  0, 32'h300, 16'hFFFE, 16'd2));
        tb_.push_back(mk(1, 5, 0,  6, 5'b11011, 0, 32'h304, 0, 0, 1, 1,    0, 5'b00000, 0,  0,  1,  0, 32'h300, 16'hFFFF, 16'd2));
        tb_.push_back(mk(1, 5, 0,  6, 5'b11011, 0, 32'h304, 0, 0, 0, 0,    1, 5'b11011, 0,  6,  5,  0, 32'h304, 16'hFFFF, 16'd2));
        tb_.push_back(mk(1, 0, 6,  7, 5'b10000, 0, 32'h308, 0, 0, 1, 1,    0, 5'b00000, 0,  0,  5,  0, 32'h304, 16'hFFFF, 16'd2));
        tb_.push_back(mk(1, 0, 6,  7, 5'b10000, 0, 32'h308, 0, 0, 0, 0,    1, 5'b10000, 0,  7,  0,  6, 32'h308, 16'hFFFF, 16'd2));

        rv = mk(1, 2, 3, 15, 5'b10000, 2, 32'h400, 0, 0, 0, 0,             1, 5'b10000, 2, 15,  2,  3, 32'h400, 16'd0, 16'd0);

        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        repeat (2) @(negedge clk);
        chk_all_zero();
        reset_n = 1'b1;

        foreach (ta[i]) run_vec(ta[i]);
        force dut.bubble_cnt = 16'hFFFE;
        #1;
        release dut.bubble_cnt;
        foreach (tb_[i]) run_vec(tb_[i]);

        // Asynchronous reset between edges while EX holds a valid instruction.
        @(posedge clk);
        @(negedge clk);
        chk("pre_reset_ex_valid", {31'd0, bus.ex_valid}, 32'd1);
        drive(rv);
        #2;
        reset_n = 1'b0;
        #1;
        chk_all_zero();
        chk("rst_load_use_stall", {31'd0, bus.load_use_stall}, 32'd0);
        #1;
        reset_n = 1'b1;
        exp_q.push_back(rv);

        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
